// File: rtl/nco_mc_iq.sv
// nco_mc_iq: time-multiplexed quadrature NCO serving up to 8 channels in
// round-robin order. Each channel has its own phase accumulator, increment
// and offset. One sin/cos pair tagged with its channel leaves per enabled
// clock after a four-stage pipeline:
//   phase add -> quadrant/address -> ROM read -> mirror/negate.
// The quarter-wave table is computed from the rounding formula at
// elaboration time, so no init file is needed to build or simulate.
// Optional feature: define NCO_DITHER_EN to add LFSR phase dither ahead of
// the quadrant/address extraction.
module nco_mc_iq #(
    parameter int nc  = 4,
    parameter int apr = 32,
    parameter int raw = 8,
    parameter int mpr = 12
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           clken,
    input  logic           cfg_wr,
    input  logic           cfg_sel,
    input  logic [2:0]     cfg_chan,
    input  logic [apr-1:0] cfg_data,
    input  logic           phase_clr_i,
    output logic [mpr-1:0] fsin_o,
    output logic [mpr-1:0] fcos_o,
    output logic [2:0]     out_chan,
    output logic           out_valid
);

    // Quarter-wave entry k = round((2^(mpr-1)-1) * sin(pi/2*(k+0.5)/2^raw)).
    // Evaluated with a Q30 Taylor series; the residual error is far below
    // the rounding step of the output.
    function automatic logic [mpr-2:0] qw_entry(input int k);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint amp;
        longint prod;
        x    = (64'sd1686629713 * longint'(32'sd2 * k + 32'sd1)) >>> (raw + 1);
        x2   = (x * x) >>> 32'd30;
        term = x;
        sum  = x;
        for (int n = 1; n <= 10; n++) begin
            term = (term * x2) >>> 32'd30;
            term = -term / longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
            sum  = sum + term;
        end
        amp  = (64'sd1 <<< (mpr - 1)) - 64'sd1;
        prod = (amp * sum + (64'sd1 <<< 32'd29)) >>> 32'd30;
        qw_entry = prod[mpr-2:0];
    endfunction

    // Channel sequencing and per-channel state. Arrays are sized for the
    // full 3-bit channel space; entries at or above nc are never written.
    logic [2:0]     ch_r;
    logic [apr-1:0] acc_r [8];
    logic [apr-1:0] inc_r [8];
    logic [apr-1:0] off_r [8];

    // Stage 1 registers
    logic [apr-1:0] ph_r;
    logic [2:0]     tag1_r;
    logic           v1_r;

    // Stage 2 registers
    logic [raw-1:0] sin_addr_r;
    logic [raw-1:0] cos_addr_r;
    logic           sin_neg2_r;
    logic           cos_neg2_r;
    logic [2:0]     tag2_r;
    logic           v2_r;

    // Stage 3 registers
    logic [mpr-2:0] sin_mag_r;
    logic [mpr-2:0] cos_mag_r;
    logic           sin_neg3_r;
    logic           cos_neg3_r;
    logic [2:0]     tag3_r;
    logic           v3_r;

    // Stage 2 combinational decode
    logic [apr-1:0] ph_d_s;
    logic [1:0]     q_s;
    logic [raw-1:0] a_s;
    logic [raw-1:0] sin_addr_s;
    logic [raw-1:0] cos_addr_s;
    logic           sin_neg_s;
    logic           cos_neg_s;
    logic           unused_ph_s;

    // Quarter-wave table, read through two independent ports
    logic [mpr-2:0] rom_s [2**raw];

    for (genvar k = 0; k < 2**raw; k++) begin : g_rom
        localparam logic [mpr-2:0] ENTRY = qw_entry(k);
        assign rom_s[k] = ENTRY;
    end

`ifdef NCO_DITHER_EN
    logic [31:0] lfsr_r;

    // Galois LFSR x^32+x^22+x^2+x+1, one step per enabled cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r <= 32'd1;
        end else if (clken) begin
            if (lfsr_r[0]) begin
                lfsr_r <= (lfsr_r >> 1) ^ 32'h8020_0003;
            end else begin
                lfsr_r <= lfsr_r >> 1;
            end
        end
    end

    // Dither only perturbs the bits below the ROM address; acc is untouched
    assign ph_d_s = ph_r + apr'(lfsr_r[apr-raw-3:0]);
`else
    assign ph_d_s = ph_r;
`endif

    // Bits below the table address only matter through the dither carry
    assign unused_ph_s = ^ph_d_s[apr-3-raw:0];

    // Round-robin channel counter, advancing on enabled cycles only
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_r <= 3'd0;
        end else if (clken) begin
            if (ch_r == 3'(nc - 1)) begin
                ch_r <= 3'd0;
            end else begin
                ch_r <= ch_r + 3'd1;
            end
        end
    end

    // Configuration writes land at the edge regardless of clken; a visit in
    // the same cycle still reads the old value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 8; c++) begin
                inc_r[c] <= '0;
                off_r[c] <= '0;
            end
        end else if (cfg_wr && ({1'b0, cfg_chan} < 4'(nc))) begin
            if (cfg_sel) begin
                off_r[cfg_chan] <= cfg_data;
            end else begin
                inc_r[cfg_chan] <= cfg_data;
            end
        end
    end

    // Phase accumulators: visited channel advances, a clear zeroes them all
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 8; c++) begin
                acc_r[c] <= '0;
            end
        end else if (clken) begin
            if (phase_clr_i) begin
                for (int c = 0; c < 8; c++) begin
                    acc_r[c] <= '0;
                end
            end else begin
                acc_r[ch_r] <= acc_r[ch_r] + inc_r[ch_r];
            end
        end
    end

    // Stage 1: output phase of the visited channel uses the pre-update acc
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_r   <= '0;
            tag1_r <= 3'd0;
            v1_r   <= 1'b0;
        end else if (clken) begin
            ph_r   <= acc_r[ch_r] + off_r[ch_r];
            tag1_r <= ch_r;
            v1_r   <= 1'b1;
        end
    end

    // Quadrant decode: sine mirrors on odd quadrants, cosine is quadrant+1
    always_comb begin
        q_s        = ph_d_s[apr-1:apr-2];
        a_s        = ph_d_s[apr-3:apr-2-raw];
        sin_addr_s = a_s;
        cos_addr_s = ~a_s;
        if (q_s[0]) begin
            sin_addr_s = ~a_s;
            cos_addr_s = a_s;
        end else begin
            sin_addr_s = a_s;
            cos_addr_s = ~a_s;
        end
        sin_neg_s = q_s[1];
        cos_neg_s = q_s[1] ^ q_s[0];
    end

    // Stage 2: register mirrored addresses and signs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sin_addr_r <= '0;
            cos_addr_r <= '0;
            sin_neg2_r <= 1'b0;
            cos_neg2_r <= 1'b0;
            tag2_r     <= 3'd0;
            v2_r       <= 1'b0;
        end else if (clken) begin
            sin_addr_r <= sin_addr_s;
            cos_addr_r <= cos_addr_s;
            sin_neg2_r <= sin_neg_s;
            cos_neg2_r <= cos_neg_s;
            tag2_r     <= tag1_r;
            v2_r       <= v1_r;
        end
    end

    // Stage 3: registered dual-port read of the quarter-wave table
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sin_mag_r  <= '0;
            cos_mag_r  <= '0;
            sin_neg3_r <= 1'b0;
            cos_neg3_r <= 1'b0;
            tag3_r     <= 3'd0;
            v3_r       <= 1'b0;
        end else if (clken) begin
            sin_mag_r  <= rom_s[sin_addr_r];
            cos_mag_r  <= rom_s[cos_addr_r];
            sin_neg3_r <= sin_neg2_r;
            cos_neg3_r <= cos_neg2_r;
            tag3_r     <= tag2_r;
            v3_r       <= v2_r;
        end
    end

    // Stage 4: apply sign; magnitudes are mpr-1 bits so negation never wraps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsin_o    <= '0;
            fcos_o    <= '0;
            out_chan  <= 3'd0;
            out_valid <= 1'b0;
        end else if (clken) begin
            if (sin_neg3_r) begin
                fsin_o <= -{1'b0, sin_mag_r};
            end else begin
                fsin_o <= {1'b0, sin_mag_r};
            end
            if (cos_neg3_r) begin
                fcos_o <= -{1'b0, cos_mag_r};
            end else begin
                fcos_o <= {1'b0, cos_mag_r};
            end
            out_chan  <= tag3_r;
            out_valid <= v3_r;
        end
    end

endmodule

// File: tb/tb_nco_mc_iq.sv
// Testbench for nco_mc_iq (nc=4, apr=32, raw=8, mpr=12, no dither).
// A behavioural model tracks per-channel phase with plain arithmetic and
// derives each expected sample from the full-wave sine of its 10-bit phase.
module tb_nco_mc_iq;

    localparam int NC = 4;

    logic        clk;
    logic        reset_n;
    logic        clken;
    logic        cfg_wr;
    logic        cfg_sel;
    logic [2:0]  cfg_chan;
    logic [31:0] cfg_data;
    logic        phase_clr_i;
    logic [11:0] fsin_o;
    logic [11:0] fcos_o;
    logic [2:0]  out_chan;
    logic        out_valid;

    nco_mc_iq #(.nc(NC), .apr(32), .raw(8), .mpr(12)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clken       (clken),
        .cfg_wr      (cfg_wr),
        .cfg_sel     (cfg_sel),
        .cfg_chan    (cfg_chan),
        .cfg_data    (cfg_data),
        .phase_clr_i (phase_clr_i),
        .fsin_o      (fsin_o),
        .fcos_o      (fcos_o),
        .out_chan    (out_chan),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int s;
        int c;
    } smp_t;

    int          n_tests;
    int          n_fail;
    bit [31:0]   m_acc [NC];
    bit [31:0]   m_inc [NC];
    bit [31:0]   m_off [NC];
    int          m_ch;
    int          m_en;
    smp_t        mq[$];
    smp_t        cur_exp;
    bit          new_samp;

    int qs_sin [4] = '{6, 2047, -6, -2047};
    int qs_cos [4] = '{2047, -6, -2047, 6};

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else return -$rtoi(-x + 0.5);
    endfunction

    // Table resolution is 1024 points per turn, sampled at bin centres
    function automatic real ang(input bit [31:0] ph);
        return 2.0 * 3.14159265358979323846 * (real'(ph[31:22]) + 0.5) / 1024.0;
    endfunction

    function automatic int ref_sin(input bit [31:0] ph);
        return rnd(2047.0 * $sin(ang(ph)));
    endfunction

    function automatic int ref_cos(input bit [31:0] ph);
        return rnd(2047.0 * $cos(ang(ph)));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            m_acc[i] = 32'd0;
            m_inc[i] = 32'd0;
            m_off[i] = 32'd0;
        end
        m_ch = 0;
        m_en = 0;
        mq.delete();
        new_samp = 1'b0;
        cur_exp.ch = 0;
        cur_exp.s = 0;
        cur_exp.c = 0;
    endtask

    // Apply one clock edge to the model using the inputs present at that edge
    task automatic model_edge();
        smp_t e;
        bit [31:0] ph;
        int c;
        new_samp = 1'b0;
        if (clken) begin
            c = m_ch;
            ph = m_acc[c] + m_off[c];
            e.ch = c;
            e.s = ref_sin(ph);
            e.c = ref_cos(ph);
            mq.push_back(e);
            if (phase_clr_i) begin
                for (int i = 0; i < NC; i++) m_acc[i] = 32'd0;
            end else begin
                m_acc[c] = m_acc[c] + m_inc[c];
            end
            m_ch = (c + 1) % NC;
            m_en++;
            if (mq.size() == 4) begin
                cur_exp = mq.pop_front();
                new_samp = 1'b1;
            end
        end
        if (cfg_wr && int'(cfg_chan) < NC) begin
            if (cfg_sel) m_off[cfg_chan] = cfg_data;
            else m_inc[cfg_chan] = cfg_data;
        end
    endtask

    task automatic compare_out();
        check_val("out_valid", int'(out_valid), (m_en >= 4) ? 1 : 0);
        if (m_en >= 4) begin
            check_val("out_chan", int'(out_chan), cur_exp.ch);
            check_val("fsin", int'($signed(fsin_o)), cur_exp.s);
            check_val("fcos", int'($signed(fcos_o)), cur_exp.c);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_out();
    endtask

    task automatic cfg_write(input bit sel, input int chn, input bit [31:0] data);
        cfg_wr = 1'b1;
        cfg_sel = sel;
        cfg_chan = 3'(chn);
        cfg_data = data;
        cycle();
        cfg_wr = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_sin"}, int'(fsin_o), 0);
        check_val({tag, "_cos"}, int'(fcos_o), 0);
        check_val({tag, "_chan"}, int'(out_chan), 0);
        check_val({tag, "_valid"}, int'(out_valid), 0);
    endtask

    initial begin
        int idx;
        int r;
        n_tests = 0;
        n_fail = 0;
        reset_n = 1'b0;
        clken = 1'b0;
        cfg_wr = 1'b0;
        cfg_sel = 1'b0;
        cfg_chan = 3'd0;
        cfg_data = 32'd0;
        phase_clr_i = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        #10;
        reset_n = 1'b1;

        // Quadrant stepping on channel 0 (write while clken=0)
        clken = 1'b0;
        cfg_write(1'b0, 0, 32'h4000_0000);
        clken = 1'b1;
        idx = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (new_samp && cur_exp.ch == 0) begin
                check_val("quad_sin", int'($signed(fsin_o)), qs_sin[idx % 4]);
                check_val("quad_cos", int'($signed(fcos_o)), qs_cos[idx % 4]);
                idx++;
            end
        end

        // Round-robin with per-channel quarter-turn offsets
        clken = 1'b0;
        cfg_write(1'b0, 0, 32'd0);
        for (int c = 0; c < NC; c++) cfg_write(1'b1, c, 32'(c) << 30);
        clken = 1'b1;
        phase_clr_i = 1'b1;
        cycle();
        phase_clr_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (i >= 6 && new_samp) begin
                check_val("rr_sin", int'($signed(fsin_o)), qs_sin[cur_exp.ch]);
                check_val("rr_cos", int'($signed(fcos_o)), qs_cos[cur_exp.ch]);
            end
        end

        // Randomized traffic: gating, config writes (incl. invalid channels
        // and visit collisions) and phase clears
        for (int i = 0; i < 1500; i++) begin
            clken = ($urandom_range(0, 99) < 75);
            cfg_wr = ($urandom_range(0, 99) < 25);
            cfg_sel = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            cfg_chan = (r < 8) ? 3'(r) : 3'(m_ch);
            case ($urandom_range(0, 2))
                0: cfg_data = $urandom;
                1: cfg_data = 32'($urandom_range(0, 3)) << 30;
                default: cfg_data = 32'($urandom_range(0, 255)) << 22;
            endcase
            phase_clr_i = ($urandom_range(0, 99) < 3);
            cycle();
        end
        cfg_wr = 1'b0;
        phase_clr_i = 1'b0;

        // Asynchronous reset mid-stream, away from any clock edge
        clken = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        #3;
        reset_n = 1'b1;

        // Offset write colliding with the first visit of channel 0
        clken = 1'b1;
        cfg_write(1'b1, 0, 32'h8000_0000);
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (new_samp && cur_exp.ch == 0 && idx < 2) begin
                check_val("offwr_sin", int'($signed(fsin_o)), (idx == 0) ? 6 : -6);
                check_val("offwr_cos", int'($signed(fcos_o)), (idx == 0) ? 2047 : -2047);
                idx++;
            end
        end

        // Short random tail after the reset
        for (int i = 0; i < 300; i++) begin
            clken = ($urandom_range(0, 99) < 70);
            cfg_wr = ($urandom_range(0, 99) < 20);
            cfg_sel = 1'($urandom_range(0, 1));
            cfg_chan = 3'($urandom_range(0, 7));
            cfg_data = $urandom;
            phase_clr_i = ($urandom_range(0, 99) < 2);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
